// File: rtl/multi_wave_display.sv
// multi_wave_display: overlays NUM_CH sampled traces inside a screen window,
// each trace coloured from a frame-rate HSV rainbow offset per channel.
module multi_wave_display #(
  parameter int NUM_CH      = 2,
  parameter int SAMPLE_W    = 8,
  parameter int ADDR_W      = 8,
  parameter int X_START     = 256,
  parameter int Y_START     = 0,
  parameter int Y_OFFSET    = 32,
  parameter int MARGIN      = 3,
  parameter int CH_HUE_STEP = 512,
  parameter int HUE_DIV     = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [10:0]                x,
  input  logic [9:0]                 y,
  input  logic                       valid,
  input  logic                       read_index,
  input  logic [NUM_CH*SAMPLE_W-1:0] rd_data,
  input  logic [1:0]                 mode,
  input  logic [NUM_CH-1:0]          ch_enable,
  input  logic                       freeze,
  output logic [ADDR_W:0]            read_address,
  output logic                       valid_pixel,
  output logic [7:0]                 r,
  output logic [7:0]                 g,
  output logic [7:0]                 b
);

  localparam int WIN_W = 2 ** (ADDR_W + 1);
  localparam logic [10:0] HUE_MAX = 11'd1535;

  logic [11:0]       xRel;
  logic [10:0]       yRel;
  logic [ADDR_W-1:0] idx;
  logic [7:0]        yv;
  logic              inX;
  logic              inY;
  logic              inMargin;
  logic              frameStart;

  // Coordinates left of / above the window wrap to large values and fail the range test.
  assign xRel     = {1'b0, x} - 12'(X_START);
  assign yRel     = {1'b0, y} - 11'(Y_START);
  assign idx      = xRel[ADDR_W:1];
  assign yv       = yRel[8:1];
  assign inX      = xRel < 12'(WIN_W);
  assign inY      = yRel < 11'd512;
  assign inMargin = (idx >= (ADDR_W)'(MARGIN)) && (idx <= (ADDR_W)'(2 ** ADDR_W - 1 - MARGIN));
  assign frameStart   = valid && (x == 11'd0) && (y == 10'd0);
  assign read_address = {read_index, idx};

  logic [ADDR_W:0] prevAddr_q;
  logic            chg_q;
  logic [7:0]      cur_q [NUM_CH];
  logic [7:0]      prv_q [NUM_CH];

  always_ff @(posedge clk) begin
    if (reset) begin
      prevAddr_q <= '0;
      chg_q      <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        cur_q[c] <= '0;
        prv_q[c] <= '0;
      end
    end else begin
      prevAddr_q <= read_address;
      chg_q      <= (read_address != prevAddr_q);
      if (chg_q) begin
        for (int c = 0; c < NUM_CH; c++) begin
          cur_q[c] <= (rd_data[c*SAMPLE_W + SAMPLE_W - 8 +: 8] >> 1) + 8'(Y_OFFSET);
          prv_q[c] <= cur_q[c];
        end
      end
    end
  end

  logic [10:0] hue_q, hue_d;
  logic [15:0] div_q, div_d;

  always_comb begin
    hue_d = hue_q;
    div_d = div_q;
    if (frameStart && !freeze) begin
      if (div_q == 16'(HUE_DIV - 1)) begin
        div_d = '0;
        hue_d = (hue_q == HUE_MAX) ? 11'd0 : hue_q + 11'd1;
      end else begin
        div_d = div_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hue_q <= '0;
      div_q <= '0;
    end else begin
      hue_q <= hue_d;
      div_q <= div_d;
    end
  end

  function automatic logic [10:0] chanHue(input logic [10:0] base, input int c);
    logic [11:0] s;
    s = {1'b0, base} + 12'((c * CH_HUE_STEP) % 1536);
    return (s >= 12'd1536) ? 11'(s - 12'd1536) : s[10:0];
  endfunction

  function automatic logic [23:0] hueToRgb(input logic [10:0] hc);
    logic [7:0] f;
    f = hc[7:0];
    case (hc[10:8])
      3'd0:    return {8'hFF, f, 8'h00};
      3'd1:    return {~f, 8'hFF, 8'h00};
      3'd2:    return {8'h00, 8'hFF, f};
      3'd3:    return {8'h00, ~f, 8'hFF};
      3'd4:    return {f, 8'h00, 8'hFF};
      default: return {8'hFF, 8'h00, ~f};
    endcase
  endfunction

  logic [NUM_CH-1:0] hit;
  logic [23:0]       rgb_d;
  logic              traceHit;

  // Walk channels from highest to lowest so the lowest-index hit sets the colour last.
  always_comb begin
    hit      = '0;
    rgb_d    = '0;
    traceHit = 1'b0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      case (mode)
        2'd1:    traceHit = (yv == cur_q[c]);
        2'd2:    traceHit = ((yv >= cur_q[c]) && (yv <= 8'd96)) || ((yv <= cur_q[c]) && (yv >= 8'd96));
        default: traceHit = ((yv >= prv_q[c]) && (yv <= cur_q[c])) || ((yv >= cur_q[c]) && (yv <= prv_q[c]));
      endcase
      hit[c] = traceHit && ch_enable[c] && valid && inX && inY && inMargin;
      if (hit[c]) begin
        rgb_d = hueToRgb(chanHue(hue_q, c));
      end
    end
  end

  logic        validPixel_q;
  logic [23:0] rgb_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      validPixel_q <= 1'b0;
      rgb_q        <= '0;
    end else begin
      validPixel_q <= |hit;
      rgb_q        <= rgb_d;
    end
  end

  assign valid_pixel = validPixel_q;
  assign r = rgb_q[23:16];
  assign g = rgb_q[15:8];
  assign b = rgb_q[7:0];

endmodule
